// File: rtl/wallace_reduce_pipe.sv
// Pipelined 6x6 Wallace reduction front end: partial products are compressed to a sum row and
// a carry row (out_sum + out_carry == in_a * in_b) under a valid/ready handshake.
// REG_PP selects a two-stage (6->4 registered, 4->2 registered) or one-stage pipeline.
module wallace_reduce_pipe #(
  parameter int unsigned REG_PP = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_a,
  input  logic [5:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_sum,
  output logic [11:0]      out_carry,
  output logic [TAG_W-1:0] out_tag
);

  typedef logic [11:0] row_t;

  // Column-wise 3:2 counter over whole rows; the carry moves one column left. Columns with only
  // two live bits reduce to half adders. Every row is bounded by the product (< 4096), so no
  // carry can ever reach bit 12.
  function automatic logic [23:0] csa(input row_t x, input row_t y, input row_t z);
    row_t s;
    row_t c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [5:0][11:0] pp;
  logic [3:0][11:0] l1;

  // Partial-product rows: row i is in_a gated by in_b[i], weighted 2^i.
  always_comb begin
    pp = '0;
    for (int i = 0; i < 6; i++) begin
      pp[i] = row_t'(in_a & {6{in_b[i]}}) << i;
    end
  end

  // First reduction layer: 6 rows to 4 rows.
  always_comb begin
    l1 = '0;
    {l1[1], l1[0]} = csa(pp[0], pp[1], pp[2]);
    {l1[3], l1[2]} = csa(pp[3], pp[4], pp[5]);
  end

  logic             s2_adv;
  logic             s2_in_valid;
  logic [3:0][11:0] s2_in_rows;
  logic [TAG_W-1:0] s2_in_tag;

  logic             out_valid_q;
  row_t             out_sum_q;
  row_t             out_carry_q;
  logic [TAG_W-1:0] out_tag_q;

  assign s2_adv = !out_valid_q | out_ready;

  if (REG_PP != 0) begin : g_reg_pp
    logic             s1_valid_q;
    logic [3:0][11:0] s1_rows_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_adv;

    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 occupancy: refilled (or emptied) whenever the stage may advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
    end

    // Stage 1 data: captured only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_rows_q <= '0;
        s1_tag_q  <= '0;
      end else if (in_valid && s1_adv) begin
        s1_rows_q <= l1;
        s1_tag_q  <= in_tag;
      end
    end

    assign s2_in_valid = s1_valid_q;
    assign s2_in_rows  = s1_rows_q;
    assign s2_in_tag   = s1_tag_q;
  end else begin : g_no_reg_pp
    assign in_ready    = s2_adv;
    assign s2_in_valid = in_valid;
    assign s2_in_rows  = l1;
    assign s2_in_tag   = in_tag;
  end

  row_t l2_s;
  row_t l2_c;
  row_t sum_d;
  row_t carry_d;

  // Second reduction: 4 rows to 3, then 3 to the final 2.
  always_comb begin
    l2_s    = '0;
    l2_c    = '0;
    sum_d   = '0;
    carry_d = '0;
    {l2_c, l2_s}     = csa(s2_in_rows[0], s2_in_rows[1], s2_in_rows[2]);
    {carry_d, sum_d} = csa(l2_s, l2_c, s2_in_rows[3]);
  end

  // Output occupancy: holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s2_in_valid;
    end
  end

  // Output data: captured only when a valid operation moves into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_q   <= '0;
      out_carry_q <= '0;
      out_tag_q   <= '0;
    end else if (s2_in_valid && s2_adv) begin
      out_sum_q   <= sum_d;
      out_carry_q <= carry_d;
      out_tag_q   <= s2_in_tag;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Bench for wallace_reduce_pipe: a REG_PP=1 and a REG_PP=0 instance share the stimulus; each
// has its own handshake outputs and expected-result queue.
module tb_wallace_reduce_pipe;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [5:0]    in_a = '0;
  logic [5:0]    in_b = '0;
  logic [TW-1:0] in_tag = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [11:0]   out_sum1, out_carry1, out_sum0, out_carry0;
  logic [TW-1:0] out_tag1, out_tag0;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0]  VA [5] = '{6'd63, 6'd0, 6'd63, 6'd1, 6'd32};
  localparam logic [5:0]  VB [5] = '{6'd63, 6'd63, 6'd0, 6'd1, 6'd2};
  localparam logic [12:0] VP [5] = '{13'd3969, 13'd0, 13'd0, 13'd1, 13'd64};

  always #5 clk = ~clk;

  wallace_reduce_pipe #(.REG_PP(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
    .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_carry(out_carry1), .out_tag(out_tag1)
  );

  wallace_reduce_pipe #(.REG_PP(0), .TAG_W(TW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a),
    .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_carry(out_carry0), .out_tag(out_tag0)
  );

  function automatic logic [12:0] rsum(input logic [11:0] s, input logic [11:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 6'h2a; in_b = 6'h15; in_tag = 4'hf; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if ({out_valid1, in_ready1, out_sum1, out_carry1, out_tag1} !== {2'b01, 12'd0, 12'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state1: got v=%b rdy=%b s=%0d c=%0d t=%0d, want v=0 rdy=1 s=0 c=0 t=0",
               out_valid1, in_ready1, out_sum1, out_carry1, out_tag1);
    end
    n_tests++;
    if ({out_valid0, in_ready0, out_sum0, out_carry0, out_tag0} !== {2'b01, 12'd0, 12'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state0: got v=%b rdy=%b s=%0d c=%0d t=%0d, want v=0 rdy=1 s=0 c=0 t=0",
               out_valid0, in_ready0, out_sum0, out_carry0, out_tag0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_a = 6'd5; in_b = 6'd7; in_tag = 4'd1; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_accept: got in_ready=%b want 1", in_ready1);
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    n_tests++;
    if (out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_lat_early: got out_valid=%b want 0", out_valid1);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {1'b1, 13'd35, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_lat_result: got v=%b sum=%0d t=%0d, want v=1 sum=35 t=1",
               out_valid1, rsum(out_sum1, out_carry1), out_tag1);
    end
  endtask

  task automatic test_corners();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = VA[i]; in_b = VB[i]; in_tag = 4'(i + 2); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; #1;
      n_tests++;
      if ({out_valid0, rsum(out_sum0, out_carry0), out_carry0[0], out_tag0, out_valid1} !==
          {1'b1, VP[i], 1'b0, 4'(i + 2), 1'b0}) begin
        n_fail++;
        $display("FAIL corner0[%0d]: got v=%b sum=%0d c0=%b t=%0d v1=%b, want v=1 sum=%0d c0=0 t=%0d v1=0",
                 i, out_valid0, rsum(out_sum0, out_carry0), out_carry0[0], out_tag0, out_valid1,
                 VP[i], i + 2);
      end
      @(negedge clk); #1;
      n_tests++;
      if ({out_valid1, rsum(out_sum1, out_carry1), out_carry1[0], out_tag1, out_valid0} !==
          {1'b1, VP[i], 1'b0, 4'(i + 2), 1'b0}) begin
        n_fail++;
        $display("FAIL corner1[%0d]: got v=%b sum=%0d c0=%b t=%0d v0=%b, want v=1 sum=%0d c0=0 t=%0d v0=0",
                 i, out_valid1, rsum(out_sum1, out_carry1), out_carry1[0], out_tag1, out_valid0,
                 VP[i], i + 2);
      end
    end
  endtask

  // Streaming test: exhaustive operands at full rate, or random valid/ready with random operands.
  task automatic test_stream(input bit rnd, input int n_ops, input string nm);
    logic [16:0] q1[$];
    logic [16:0] q0[$];
    int          issued = 0;
    int          cyc = 0;
    int          budget = n_ops * 6 + 100;
    bit          hold = 1'b0;
    do_reset();
    while ((issued < n_ops || q1.size() > 0 || q0.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (!hold) begin
        if (issued < n_ops && (!rnd || $urandom_range(1) == 1)) begin
          in_valid = 1'b1;
          in_tag   = 4'(issued);
          if (rnd) begin
            in_a = 6'($urandom_range(63));
            in_b = 6'($urandom_range(63));
          end else begin
            in_a = 6'(issued >> 6);
            in_b = 6'(issued);
          end
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (!rnd && cyc >= 1 && cyc <= n_ops + 1) begin
        n_tests++;
        if (out_valid1 !== (cyc >= 2) || out_valid0 !== (cyc <= n_ops)) begin
          n_fail++;
          $display("FAIL %s_rate cyc %0d: got v1=%b v0=%b, want v1=%b v0=%b", nm, cyc,
                   out_valid1, out_valid0, cyc >= 2, cyc <= n_ops);
        end
      end
      if (out_valid1 === 1'b1) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious1 cyc %0d: got out_valid=1 want 0", nm, cyc);
        end else if ({rsum(out_sum1, out_carry1), out_carry1[0], out_tag1} !==
                     {q1[0][16:4], 1'b0, q1[0][3:0]}) begin
          n_fail++;
          $display("FAIL %s_data1 cyc %0d: got sum=%0d c0=%b t=%0d, want sum=%0d c0=0 t=%0d", nm,
                   cyc, rsum(out_sum1, out_carry1), out_carry1[0], out_tag1, q1[0][16:4],
                   q1[0][3:0]);
        end
        if (out_ready && q1.size() > 0) void'(q1.pop_front());
      end
      if (out_valid0 === 1'b1) begin
        n_tests++;
        if (q0.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious0 cyc %0d: got out_valid=1 want 0", nm, cyc);
        end else if ({rsum(out_sum0, out_carry0), out_carry0[0], out_tag0} !==
                     {q0[0][16:4], 1'b0, q0[0][3:0]}) begin
          n_fail++;
          $display("FAIL %s_data0 cyc %0d: got sum=%0d c0=%b t=%0d, want sum=%0d c0=0 t=%0d", nm,
                   cyc, rsum(out_sum0, out_carry0), out_carry0[0], out_tag0, q0[0][16:4],
                   q0[0][3:0]);
        end
        if (out_ready && q0.size() > 0) void'(q0.pop_front());
      end
      if (in_valid && in_ready1) q1.push_back({13'(in_a) * 13'(in_b), in_tag});
      if (in_valid && in_ready0) q0.push_back({13'(in_a) * 13'(in_b), in_tag});
      if (in_valid && in_ready1) issued++;
      hold = in_valid && !in_ready1;
      cyc++;
    end
    n_tests++;
    if (issued != n_ops || q1.size() != 0 || q0.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got issued=%0d pending1=%0d pending0=%0d, want %0d 0 0", nm,
               issued, q1.size(), q0.size(), n_ops);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 6'd3; in_b = 6'd4; in_tag = 4'd1; #1;
    n_tests++;
    if ({in_ready1, in_ready0} !== 2'b11) begin
      n_fail++; $display("FAIL bp_accept1: got rdy1=%b rdy0=%b want 1 1", in_ready1, in_ready0);
    end
    @(negedge clk);
    in_a = 6'd5; in_b = 6'd6; in_tag = 4'd2; #1;
    n_tests++;
    if ({in_ready1, in_ready0, out_valid1, out_valid0, out_tag0} !== {4'b1001, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_accept2: got rdy1=%b rdy0=%b v1=%b v0=%b t0=%0d, want 1 0 0 1 1",
               in_ready1, in_ready0, out_valid1, out_valid0, out_tag0);
    end
    @(negedge clk);
    in_a = 6'd7; in_b = 6'd8; in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++;
      if ({in_ready1, out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {2'b01, 13'd12, 4'd1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sum=%0d t=%0d, want rdy=0 v=1 sum=12 t=1", i,
                 in_ready1, out_valid1, rsum(out_sum1, out_carry1), out_tag1);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    n_tests++;
    if ({in_ready1, out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {2'b11, 13'd12, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b v=%b sum=%0d t=%0d, want rdy=1 v=1 sum=12 t=1",
               in_ready1, out_valid1, rsum(out_sum1, out_carry1), out_tag1);
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    n_tests++;
    if ({out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {1'b1, 13'd30, 4'd2}) begin
      n_fail++;
      $display("FAIL bp_drain2: got v=%b sum=%0d t=%0d, want v=1 sum=30 t=2",
               out_valid1, rsum(out_sum1, out_carry1), out_tag1);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {1'b1, 13'd56, 4'd3}) begin
      n_fail++;
      $display("FAIL bp_drain3: got v=%b sum=%0d t=%0d, want v=1 sum=56 t=3",
               out_valid1, rsum(out_sum1, out_carry1), out_tag1);
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: got out_valid=%b want 0", out_valid1);
    end
  endtask

  task automatic test_midflight_reset();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 6'd2; in_b = 6'd3; in_tag = 4'd7;
    @(negedge clk);
    in_a = 6'd4; in_b = 6'd4; in_tag = 4'd8;
    @(negedge clk);
    in_valid = 1'b0; #1;
    n_tests++;
    if ({out_valid1, in_ready1} !== 2'b10) begin
      n_fail++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid1, in_ready1);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid1, in_ready1, out_sum1, out_carry1, out_tag1, out_valid0} !==
        {2'b01, 12'd0, 12'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b rdy=%b s=%0d c=%0d t=%0d v0=%b, want 0 1 0 0 0 0",
               out_valid1, in_ready1, out_sum1, out_carry1, out_tag1, out_valid0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 6'd9; in_b = 6'd9; in_tag = 4'd5; #1;
    n_tests++;
    if ({out_valid1, out_valid0, in_ready1} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_stale: got v1=%b v0=%b rdy=%b want 0 0 1", out_valid1, out_valid0,
               in_ready1);
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    n_tests++;
    if ({out_valid1, out_valid0, rsum(out_sum0, out_carry0), out_tag0} !== {2'b01, 13'd81, 4'd5}) begin
      n_fail++;
      $display("FAIL mid_next0: got v1=%b v0=%b sum0=%0d t0=%0d, want 0 1 81 5", out_valid1,
               out_valid0, rsum(out_sum0, out_carry0), out_tag0);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({out_valid1, rsum(out_sum1, out_carry1), out_tag1} !== {1'b1, 13'd81, 4'd5}) begin
      n_fail++;
      $display("FAIL mid_next1: got v=%b sum=%0d t=%0d, want v=1 sum=81 t=5", out_valid1,
               rsum(out_sum1, out_carry1), out_tag1);
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got out_valid=%b want 0", out_valid1);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_stream(1'b0, 4096, "back_to_back");
    test_backpressure();
    test_stream(1'b1, 10000, "random_stall");
    test_midflight_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_reduce_pipe.md
# wallace_reduce_pipe

Pipelined front end of the 6x6 Wallace multiplier. Accepts two 6-bit unsigned operands under a valid/ready handshake, generates the 36 partial-product bits and reduces them through a registered Wallace tree to two 12-bit rows. Those rows feed the 12-bit carry-lookahead final adder directly: the adder's `a` input takes `out_sum` and its `b` input takes `out_carry`. Throughput is one operation per cycle, and the block stalls cleanly under backpressure.

## Interface
- `REG_PP`, default 1: 1 inserts a register after partial-product generation plus the first reduction layers (latency 2); 0 removes it (latency 1).
- `TAG_W`, default 4: width of the sideband tag carried alongside each operation; must be ≥ 1.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept this cycle.
- `in_a`  in  6  multiplicand, unsigned.
- `in_b`  in  6  multiplier, unsigned.
- `in_tag`  in  TAG_W  opaque tag, returned unchanged with the result.
- `out_valid`  out  1  result rows present.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_sum`  out  12  Wallace sum row.
- `out_carry`  out  12  Wallace carry row; bit 0 is always 0.
- `out_tag`  out  TAG_W  tag of the operation on the output.

## Operation
- Partial products: pp[i][j] = in_a[j] & in_b[i], weighted 2^(i+j).
- Stage 1 (present when REG_PP=1):
  - Reduce 6 rows to 4 rows with full adders and half adders (3:2 and 2:2 counters) per column.
  - Register the result with its valid bit and tag.
- Stage 2:
  - Reduce 4 rows to 2 rows.
  - Register the result as out_sum, out_carry, out_tag and out_valid.
  - When REG_PP=0, the whole 6-to-2 reduction sits in front of this register.
- Arithmetic invariant: out_sum + out_carry == in_a * in_b exactly, as an unbounded integer.
  - No weight is discarded. The maximum is 63*63 = 3969 < 4096, so neither row has a bit at position 12 or above.
- Handshake, per stage, with no bubbles:
  - A transfer occurs on each edge where valid & ready.
  - A stage loads when it is empty or its contents are leaving this cycle.
  - stage2_adv = !out_valid | out_ready.
  - stage1_adv = !s1_valid | stage2_adv.
  - in_ready = stage1_adv (REG_PP=1) or stage2_adv (REG_PP=0).
  - The combinational path from out_ready to in_ready is permitted.
- Stall: while out_valid & !out_ready, out_sum, out_carry and out_tag hold stable and out_valid stays 1. Upstream stages fill, then in_ready drops.
- in_valid with in_ready low: nothing is captured. The source must hold its data.
- Data registers load only on an accepted transfer. Invalid slots keep their previous contents; those contents are don't-care but must be deterministic.

## Timing
- Reset state:
  - All valid bits are 0.
  - out_sum = 0, out_carry = 0, out_tag = 0.
  - in_ready = 1.
- Latency:
  - REG_PP=1: an operation accepted at edge k shows out_valid=1 after edge k+2.
  - REG_PP=0: it shows out_valid=1 after edge k+1.
- Throughput: one accept per cycle while out_ready=1.
- Simultaneous events:
  - Output leaving, stage 1 advancing and a new input arriving on the same edge all complete together, with no loss or duplication.
  - Results emerge in acceptance order, which is checkable via tag.
- Capacity: 2 operations in flight (REG_PP=1) or 1 (REG_PP=0). After that, in_ready=0 until out_ready.
- Reset asserted mid-operation:
  - All in-flight operations are discarded immediately, asynchronously.
  - Outputs return to reset values without waiting for a clock edge.
  - The first accept is allowed on the first edge after rst_n deasserts.
- No combinational path from in_a, in_b or in_tag to any output.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs -> out_valid=0, out_sum=0, out_carry=0, in_ready=1. Deassert, then accept a=5, b=7, tag=1 -> two edges later out_valid=1, out_sum+out_carry=35, out_tag=1.
- Corner values, REG_PP=1 and REG_PP=0: (63,63), (0,63), (63,0), (1,1) and (32,2) -> row sums 3969, 0, 0, 1 and 64. out_carry[0]=0 throughout.
- Full throughput: 4096 back-to-back operands (exhaustive a,b) with tag = count mod 16 and out_ready=1 -> one result per cycle after fill. Every row sum equals a*b, and tags arrive in order.
- Backpressure, REG_PP=1: issue tags 1, 2, 3 back to back with out_ready=0 -> tag 1 holds on the output. in_ready drops after two accepts, so tag 3 is not taken. Raise out_ready -> tags 1, 2, 3 emerge on consecutive cycles with the correct sums.
- Random stall: random in_valid and out_ready (50%) over 10,000 operations, checked against a scoreboard -> no loss, duplication or reordering. Outputs stay stable during every stall cycle.
- Mid-flight reset: with 2 operations in flight, pulse rst_n low between clock edges -> out_valid drops immediately. No stale result appears after release, and the next accepted operation (9*9) yields 81 with its own tag.
